// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES inverse cipher. Each inverse round takes one clock and works
// on a single 128-bit state register. Round keys come from an external key
// store that is read combinationally through rk_idx/rk_data.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   in_valid   : ciphertext block present
//   in_ready   : engine idle and able to accept a block
//   in_data    : ciphertext, bits [127:120] are byte 0
//   rk_idx     : round-key index requested this cycle
//   rk_data    : round key for rk_idx, same cycle, w[4i] in [127:96]
//   out_valid  : plaintext held on out_data
//   out_ready  : sink accepts the plaintext
//   out_data   : plaintext, same byte order as in_data
//   busy       : a block is in flight or waiting to be taken
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [3:0] NR = 4'(NK + 6);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Only the three FIPS-197 key lengths have a defined round count.
  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_badNk
      $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
    end
  endgenerate

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] invSub(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (9, 11, 13, 14) as a sum of doublings.
  function automatic logic [7:0] mulConst(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^
           (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
  endfunction

  // InvShiftRows and InvSubBytes together; the S-box is bytewise so the
  // order of the two does not matter. Row r is rotated right by r columns.
  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] =
          invSub(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = mulConst(a0, 4'd14) ^ mulConst(a1, 4'd11) ^
                             mulConst(a2, 4'd13) ^ mulConst(a3, 4'd9);
      o[119 - 32 * c -: 8] = mulConst(a0, 4'd9)  ^ mulConst(a1, 4'd14) ^
                             mulConst(a2, 4'd11) ^ mulConst(a3, 4'd13);
      o[111 - 32 * c -: 8] = mulConst(a0, 4'd13) ^ mulConst(a1, 4'd9)  ^
                             mulConst(a2, 4'd14) ^ mulConst(a3, 4'd11);
      o[103 - 32 * c -: 8] = mulConst(a0, 4'd11) ^ mulConst(a1, 4'd13) ^
                             mulConst(a2, 4'd9)  ^ mulConst(a3, 4'd14);
    end
    return o;
  endfunction

  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_st;
  logic         r_outValid;
  logic [127:0] w_afterKey;
  logic [127:0] w_roundOut;

  // The last round (cnt==0) skips InvMixColumns.
  assign w_afterKey = invShiftSub(r_st) ^ rk_data;
  assign w_roundOut = (r_cnt == 4'd0) ? w_afterKey : invMixColumns(w_afterKey);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_outValid;
  assign out_data  = r_st;

  // Key index is a pure decode of state and counter.
  always_comb begin
    rk_idx = NR;
    case (r_state)
      S_ROUND: rk_idx = r_cnt;
      S_DONE:  rk_idx = 4'd0;
      default: rk_idx = NR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_st       <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st    <= in_data ^ rk_data;
            r_cnt   <= NR - 4'd1;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st <= w_roundOut;
          if (r_cnt == 4'd0) begin
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Bench for aes_inv_cipher_iter. One NK=4 instance carries most of the
// traffic; NK=6 and NK=8 instances decrypt their FIPS-197 blocks. Random
// plaintexts are encrypted by a forward AES model here and the decrypted
// result is expected to return the original plaintext.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         inValid = 1'b0;
  logic         inReady;
  logic [127:0] inData = '0;
  logic [3:0]   rkIdx;
  logic [127:0] rkData;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [127:0] outData;
  logic         busy;

  logic         inValidW = 1'b0;
  logic         outReadyW = 1'b1;
  logic         inReady6, inReady8, outValid6, outValid8, busy6, busy8;
  logic [127:0] inData6 = FIPS_CT192;
  logic [127:0] inData8 = FIPS_CT256;
  logic [127:0] rkData6, rkData8, outData6, outData8;
  logic [3:0]   rkIdx6, rkIdx8;

  logic [127:0] rks4 [0:15];
  logic [127:0] rks6 [0:15];
  logic [127:0] rks8 [0:15];
  logic [7:0]   sbTab [0:255];

  assign rkData  = rks4[rkIdx];
  assign rkData6 = rks6[rkIdx6];
  assign rkData8 = rks8[rkIdx8];

  aes_inv_cipher_iter #(.NK(4)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_data(inData), .rk_idx(rkIdx), .rk_data(rkData), .out_valid(outValid),
    .out_ready(outReady), .out_data(outData), .busy(busy)
  );

  aes_inv_cipher_iter #(.NK(6)) dut6 (
    .clk(clk), .reset(reset), .in_valid(inValidW), .in_ready(inReady6),
    .in_data(inData6), .rk_idx(rkIdx6), .rk_data(rkData6), .out_valid(outValid6),
    .out_ready(outReadyW), .out_data(outData6), .busy(busy6)
  );

  aes_inv_cipher_iter #(.NK(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(inValidW), .in_ready(inReady8),
    .in_data(inData8), .rk_idx(rkIdx8), .rk_data(rkData8), .out_valid(outValid8),
    .out_ready(outReadyW), .out_data(outData8), .busy(busy8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lastAcc = 0;
  bit haveAcc = 1'b0;
  bit b2bMode = 1'b0;
  bit prevOv = 1'b0;
  logic [127:0] expQ [$];

  // Count of rising clock edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from the field inverse plus the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbTab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbTab[w[31:24]], sbTab[w[23:16]], sbTab[w[15:8]], sbTab[w[7:0]]};
  endfunction

  function automatic logic [127:0] roundKey(input logic [255:0] key, input int nk,
                                            input int idx);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gfMul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    return {w[4 * idx], w[4 * idx + 1], w[4 * idx + 2], w[4 * idx + 3]};
  endfunction

  // Forward AES-128 with the bench key schedule.
  function automatic logic [127:0] enc128(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rks4[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8 * (4 * c + r) -: 8] = sbTab[s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32 * c -: 8];
          a1 = t[119 - 32 * c -: 8];
          a2 = t[111 - 32 * c -: 8];
          a3 = t[103 - 32 * c -: 8];
          t[127 - 32 * c -: 8] = gfMul(a0, 8'h02) ^ gfMul(a1, 8'h03) ^ a2 ^ a3;
          t[119 - 32 * c -: 8] = a0 ^ gfMul(a1, 8'h02) ^ gfMul(a2, 8'h03) ^ a3;
          t[111 - 32 * c -: 8] = a0 ^ a1 ^ gfMul(a2, 8'h02) ^ gfMul(a3, 8'h03);
          t[103 - 32 * c -: 8] = gfMul(a0, 8'h03) ^ a1 ^ a2 ^ gfMul(a3, 8'h02);
        end
      end
      s = t ^ rks4[rnd];
    end
    return s;
  endfunction

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Per-cycle scoreboard for the NK=4 instance, run at every falling edge.
  task automatic monitor();
    logic [127:0] expPt;
    if (reset) begin
      prevOv = 1'b0;
    end else begin
      if (inValid && inReady) begin
        if (b2bMode && haveAcc)
          checkOutput("b2bSpacing", 128'(cyc + 1 - lastAcc), 128'(12));
        lastAcc = cyc + 1;
        haveAcc = 1'b1;
      end
      if (outValid && !prevOv)
        checkOutput("latency", 128'(cyc - lastAcc), 128'(10));
      if (outValid && outReady) begin
        checkOutput("expectedPending", 128'(expQ.size() > 0), 128'(1));
        if (expQ.size() > 0) begin
          expPt = expQ.pop_front();
          checkOutput("plaintext", outData, expPt);
        end
      end
      prevOv = outValid;
    end
  endtask

  task automatic atDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic atSample();
    @(negedge clk);
    monitor();
  endtask

  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt,
                               input bit track);
    bit got;
    got = 1'b0;
    if (track) expQ.push_back(pt);
    inData  = ct;
    inValid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      atSample();
      if (inReady) begin
        got = 1'b1;
        checkOutput("rkAtAccept", 128'(rkIdx), 128'(10));
      end
      atDrive();
    end
    inValid = 1'b0;
    inData  = randBlock();
    checkOutput("acceptTimeout", 128'(got), 128'(1));
  endtask

  task automatic waitOutValid(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      atSample();
      if (outValid) seen = 1'b1;
      else atDrive();
    end
    checkOutput("outValidTimeout", 128'(seen), 128'(1));
  endtask

  task automatic drain(input int maxc);
    for (int n = 0; n < maxc && expQ.size() > 0; n++) begin
      atSample();
      atDrive();
    end
    checkOutput("drainTimeout", 128'(expQ.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pt;
    int accW;
    bit seen6, seen8;

    buildSbox();
    for (int i = 0; i < 16; i++) begin
      rks4[i] = (i <= 10) ? roundKey(KEY128, 4, i) : '0;
      rks6[i] = (i <= 12) ? roundKey(KEY192, 6, i) : '0;
      rks8[i] = (i <= 14) ? roundKey(KEY256, 8, i) : '0;
    end

    // Reset values while reset is still asserted.
    atDrive();
    atSample();
    checkOutput("rstInReady", 128'(inReady), 128'(1));
    checkOutput("rstRkIdx", 128'(rkIdx), 128'(10));
    checkOutput("rstOutValid", 128'(outValid), 128'(0));
    checkOutput("rstBusy", 128'(busy), 128'(0));
    checkOutput("rstOutData", outData, 128'(0));
    checkOutput("rstRkIdx6", 128'(rkIdx6), 128'(12));
    checkOutput("rstRkIdx8", 128'(rkIdx8), 128'(14));
    atDrive();
    reset = 1'b0;

    // FIPS-197 AES-128 block with the key index trace.
    outReady = 1'b1;
    applyStimulus(FIPS_CT128, FIPS_PT, 1'b1);
    for (int k = 0; k <= 10; k++) begin
      atSample();
      checkOutput("rkSeq", 128'(rkIdx), 128'((k < 10) ? 9 - k : 0));
      atDrive();
    end
    drain(20);

    // Backpressure: sink stalls for 20 cycles while the source keeps pushing.
    outReady = 1'b0;
    pt = randBlock();
    applyStimulus(enc128(pt), pt, 1'b1);
    waitOutValid(30);
    for (int i = 0; i < 20; i++) begin
      atDrive();
      inValid = 1'($urandom_range(0, 1));
      inData  = randBlock();
      atSample();
      checkOutput("bpData", outData, pt);
      checkOutput("bpInReady", 128'(inReady), 128'(0));
      checkOutput("bpOutValid", 128'(outValid), 128'(1));
    end
    atDrive();
    inValid  = 1'b0;
    outReady = 1'b1;
    atSample();
    atDrive();
    atSample();
    checkOutput("bpIdleReady", 128'(inReady), 128'(1));
    checkOutput("bpIdleBusy", 128'(busy), 128'(0));
    atDrive();

    // Back-to-back random blocks.
    haveAcc = 1'b0;
    b2bMode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pt = randBlock();
      applyStimulus(enc128(pt), pt, 1'b1);
    end
    drain(40);
    b2bMode = 1'b0;

    // Reset in the middle of a block, between clock edges.
    applyStimulus(FIPS_CT128, FIPS_PT, 1'b0);
    repeat (5) begin
      atSample();
      atDrive();
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abortOutValid", 128'(outValid), 128'(0));
    checkOutput("abortInReady", 128'(inReady), 128'(1));
    checkOutput("abortBusy", 128'(busy), 128'(0));
    checkOutput("abortRkIdx", 128'(rkIdx), 128'(10));
    atSample();
    atDrive();
    reset = 1'b0;
    applyStimulus(FIPS_CT128, FIPS_PT, 1'b1);
    drain(30);

    // Idle with out_ready toggling.
    for (int i = 0; i < 50; i++) begin
      outReady = 1'($urandom_range(0, 1));
      atSample();
      checkOutput("idleBusy", 128'(busy), 128'(0));
      checkOutput("idleOutValid", 128'(outValid), 128'(0));
      checkOutput("idleRkIdx", 128'(rkIdx), 128'(10));
      atDrive();
    end
    outReady = 1'b1;

    // AES-192 and AES-256 blocks in parallel.
    inValidW = 1'b1;
    atSample();
    checkOutput("wideReady", 128'({inReady6, inReady8}), 128'(2'b11));
    accW = cyc + 1;
    atDrive();
    inValidW = 1'b0;
    seen6 = 1'b0;
    seen8 = 1'b0;
    for (int n = 0; n < 40 && !(seen6 && seen8); n++) begin
      atSample();
      if (n == 0) checkOutput("wideBusy", 128'({busy6, busy8}), 128'(2'b11));
      if (outValid6 && !seen6) begin
        seen6 = 1'b1;
        checkOutput("latency192", 128'(cyc - accW), 128'(12));
        checkOutput("plaintext192", outData6, FIPS_PT);
      end
      if (outValid8 && !seen8) begin
        seen8 = 1'b1;
        checkOutput("latency256", 128'(cyc - accW), 128'(14));
        checkOutput("plaintext256", outData8, FIPS_PT);
      end
      atDrive();
    end
    checkOutput("wideSeen", 128'({seen6, seen8}), 128'(2'b11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
